// File: rtl/sar_conv_ctrl.sv
// Successive-approximation sequencer: runs a track phase, then an N-step binary search
// on the DAC code, and presents the finished code on a valid/ready result port.
module sar_conv_ctrl #(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         start,
    input  logic         comp_in,
    output logic         sample_en,
    output logic         conv_clk_en,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic [N-1:0] result,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         missed_start
);

    localparam int IW = $clog2(N);
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_MSB  = IW'(N - 1);
    localparam logic [N-1:0]  CODE_MSB = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   dac_q, dac_d;
    logic [N-1:0]   res_q, res_d;
    logic           sample_q, sample_d;
    logic           conv_q, conv_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           missed_q, missed_d;
    logic [N-1:0]   trial;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        res_d    = res_q;
        missed_d = 1'b0;
        trial    = dac_q;

        case (state_q)
            IDLE: begin
                dac_d = '0;
                if (start) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                missed_d = start;
                if (cnt_q == CNT_LAST) begin
                    state_d = CONVERT;
                    dac_d   = CODE_MSB;
                    idx_d   = IDX_MSB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONVERT: begin
                missed_d = start;
                // Resolve bit idx from the comparator, then raise the next trial bit.
                if (!comp_in) begin
                    trial[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    trial[idx_q - 1'b1] = 1'b1;
                    idx_d = idx_q - 1'b1;
                end else begin
                    res_d   = trial;
                    state_d = HOLD;
                end
                dac_d = trial;
            end
            HOLD: begin
                if (result_ready) begin
                    dac_d = '0;
                    if (start) begin
                        state_d = SAMPLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    missed_d = start;
                end
            end
            default: begin
                state_d = IDLE;
                dac_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they are registered with it.
        sample_d = (state_d == SAMPLE);
        conv_d   = (state_d == CONVERT);
        busy_d   = (state_d != IDLE);
        valid_d  = (state_d == HOLD);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            dac_q    <= '0;
            res_q    <= '0;
            sample_q <= 1'b0;
            conv_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            res_q    <= res_d;
            sample_q <= sample_d;
            conv_q   <= conv_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
        end
    end

    assign sample_en    = sample_q;
    assign conv_clk_en  = conv_q;
    assign dac_code     = dac_q;
    assign busy         = busy_q;
    assign result       = res_q;
    assign result_valid = valid_q;
    assign missed_start = missed_q;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Scoreboard bench for sar_conv_ctrl: default configuration plus N=4/S=1 and N=12/S=3 sweeps,
// each driven by an ideal comparator model (Vin >= dac_code).
module tb_sar_conv_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default instance: N=8, SAMPLE_CYCLES=2
    logic       start = 1'b0, result_ready = 1'b1;
    logic       comp_in, sample_en, conv_clk_en, busy, result_valid, missed_start;
    logic [7:0] dac_code, result, vin = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] ramp_seq [8];

    assign comp_in = (vin >= dac_code);

    sar_conv_ctrl u_dut (
        .clk_in(clk), .rst_n(rst_n), .start(start), .comp_in(comp_in),
        .sample_en(sample_en), .conv_clk_en(conv_clk_en), .dac_code(dac_code),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .missed_start(missed_start)
    );

    // N=4, SAMPLE_CYCLES=1
    logic        a_start = 1'b0, a_comp, a_sample, a_conv, a_busy, a_valid, a_missed;
    logic [3:0]  a_dac, a_result, a_vin = 4'h0;
    logic [3:0]  a_q[$];
    assign a_comp = (a_vin >= a_dac);

    sar_conv_ctrl #(.N(4), .SAMPLE_CYCLES(1)) u_n4 (
        .clk_in(clk), .rst_n(rst_n), .start(a_start), .comp_in(a_comp),
        .sample_en(a_sample), .conv_clk_en(a_conv), .dac_code(a_dac),
        .busy(a_busy), .result(a_result), .result_valid(a_valid),
        .result_ready(1'b1), .missed_start(a_missed)
    );

    // N=12, SAMPLE_CYCLES=3
    logic        b_start = 1'b0, b_comp, b_sample, b_conv, b_busy, b_valid, b_missed;
    logic [11:0] b_dac, b_result, b_vin = 12'h000;
    logic [11:0] b_q[$];
    assign b_comp = (b_vin >= b_dac);

    sar_conv_ctrl #(.N(12), .SAMPLE_CYCLES(3)) u_n12 (
        .clk_in(clk), .rst_n(rst_n), .start(b_start), .comp_in(b_comp),
        .sample_en(b_sample), .conv_clk_en(b_conv), .dac_code(b_dac),
        .busy(b_busy), .result(b_result), .result_valid(b_valid),
        .result_ready(1'b1), .missed_start(b_missed)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [7:0] v);
        vin = v;
        exp_q.push_back(v);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called just after the accepting edge; waits for result_valid and scores the result.
    task automatic wait_result(input int glitch_at, input bit chk_seq);
        int cyc = 0;
        int nconv = 0;
        logic [7:0] seen [8];
        logic [7:0] exp_v;
        for (int i = 0; i < 8; i++) seen[i] = 8'h00;
        while (!result_valid && cyc < 40) begin
            if (conv_clk_en) begin
                if (nconv < 8) seen[nconv] = dac_code;
                nconv++;
            end
            if (cyc == glitch_at) start = 1'b1;
            tick();
            cyc++;
            if (glitch_at >= 0 && cyc == glitch_at + 1) begin
                start = 1'b0;
                check_eq("missed_pulse", {31'd0, missed_start}, 32'd1);
            end
            if (glitch_at >= 0 && cyc == glitch_at + 2)
                check_eq("missed_clear", {31'd0, missed_start}, 32'd0);
        end
        check_eq("valid_timeout", {31'd0, result_valid}, 32'd1);
        check_eq("latency", cyc, 32'd10);
        check_eq("conv_cycles", nconv, 32'd8);
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_eq("result", {24'd0, result}, {24'd0, exp_v});
        end else begin
            check_eq("scoreboard_empty", exp_q.size(), 32'd1);
        end
        if (chk_seq)
            for (int i = 0; i < 8; i++)
                check_eq($sformatf("dac_seq%0d", i), {24'd0, seen[i]}, {24'd0, ramp_seq[i]});
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"},
                 {20'd0, sample_en, conv_clk_en, busy, result_valid, missed_start, 7'd0},
                 32'd0);
        check_eq({tag, "_dac"}, {24'd0, dac_code}, 32'd0);
        check_eq({tag, "_result"}, {24'd0, result}, 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        int cyc;
        ramp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Ramp code with full DAC trace
        start_conv(8'hA5);
        check_eq("sample_en_e0", {31'd0, sample_en}, 32'd1);
        check_eq("busy_e0", {31'd0, busy}, 32'd1);
        check_eq("dac_in_sample", {24'd0, dac_code}, 32'd0);
        wait_result(-1, 1'b1);
        tick();
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_valid", {31'd0, result_valid}, 32'd0);
        check_eq("idle_result_kept", {24'd0, result}, 32'hA5);

        // Extremes
        start_conv(8'h00); wait_result(-1, 1'b0); tick();
        start_conv(8'hFF); wait_result(-1, 1'b0); tick();
        start_conv(8'h80); wait_result(-1, 1'b0); tick();

        // Backpressure, then accept a new start on the handshake edge
        result_ready = 1'b0;
        start_conv(8'h5A);
        wait_result(-1, 1'b0);
        held = result;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", {31'd0, result_valid}, 32'd1);
            check_eq("bp_result", {24'd0, result}, {24'd0, held});
            check_eq("bp_busy", {31'd0, busy}, 32'd1);
        end
        vin = 8'h33;
        exp_q.push_back(8'h33);
        start = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        check_eq("hs_sample_en", {31'd0, sample_en}, 32'd1);
        check_eq("hs_valid_low", {31'd0, result_valid}, 32'd0);
        check_eq("hs_no_missed", {31'd0, missed_start}, 32'd0);
        wait_result(-1, 1'b0);
        tick();

        // Dropped start during CONVERT
        start_conv(8'h3C);
        wait_result(4, 1'b0);
        tick();

        // Reset on the third CONVERT cycle, then a clean conversion
        start_conv(8'hC3);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("midrst");
        void'(exp_q.pop_back());
        tick();
        start_conv(8'h6E);
        wait_result(-1, 1'b0);
        tick();

        // Sweep N=4, SAMPLE_CYCLES=1
        for (int k = 0; k < 1000; k++) begin
            a_vin = 4'($urandom);
            a_q.push_back(a_vin);
            a_start = 1'b1;
            tick();
            a_start = 1'b0;
            cyc = 0;
            while (!a_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            check_eq("n4_latency", cyc, 32'd5);
            if (a_q.size() > 0) check_eq("n4_result", {28'd0, a_result}, {28'd0, a_q.pop_front()});
            else check_eq("n4_scoreboard", a_q.size(), 32'd1);
        end
        tick();

        // Sweep N=12, SAMPLE_CYCLES=3
        for (int k = 0; k < 1000; k++) begin
            b_vin = 12'($urandom);
            b_q.push_back(b_vin);
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            cyc = 0;
            while (!b_valid && cyc < 30) begin
                tick();
                cyc++;
            end
            check_eq("n12_latency", cyc, 32'd15);
            if (b_q.size() > 0) check_eq("n12_result", {20'd0, b_result}, {20'd0, b_q.pop_front()});
            else check_eq("n12_scoreboard", b_q.size(), 32'd1);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sar_conv_ctrl.md
# sar_conv_ctrl

Successive-approximation sequencer for the SAR ADC. On a start request it runs a sample (track) phase, then performs an N-step binary search. Each step drives a trial code to the capacitive DAC and resolves it with the comparator decision. The finished code is presented on a valid/ready result port. The block also provides `conv_clk_en`, which gates the comparator/DAC clock generator to exactly N active cycles per conversion.

## Interface
- `N`, 8: converter resolution in bits (≥2).
- `SAMPLE_CYCLES`, 2: number of cycles `sample_en` is held high per conversion (≥1).

- `clk_in` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: conversion request, sampled each edge.
- `comp_in` input 1: comparator decision for the current `dac_code`; 1 means Vin ≥ DAC.
- `sample_en` output 1: track switch enable.
- `conv_clk_en` output 1: high during the compare phase; enables the comparator clock burst.
- `dac_code` output N: trial code driven to the DAC.
- `busy` output 1: high in any state other than IDLE.
- `result` output N: converted code, stable while `result_valid` is high.
- `result_valid` output 1: result handshake valid.
- `result_ready` input 1: result handshake ready.
- `missed_start` output 1: one-cycle pulse when a `start` is dropped.

## Operation
- States: IDLE, SAMPLE, CONVERT, HOLD.
- **Reset** (`rst_n`=0 at an edge, from any state, including mid-conversion):
  - State goes to IDLE.
  - All outputs go to 0: `sample_en`, `conv_clk_en`, `dac_code`, `busy`, `result`, `result_valid`, `missed_start`.
  - Sample counter and bit index are cleared.
  - Any partial conversion is discarded.
- **Start acceptance:** `start` is accepted in IDLE, or in HOLD on the same edge where `result_ready`=1. Accepted start moves the state to SAMPLE.
- **Dropped start:** `start`=1 in SAMPLE, in CONVERT, or in HOLD with `result_ready`=0 is ignored. `missed_start` pulses for exactly one cycle after that edge. Conversion is unaffected.
- **SAMPLE:**
  - `sample_en`=1, `dac_code`=0.
  - Counter runs 0..SAMPLE_CYCLES-1. When it reaches the last value, state goes to CONVERT.
  - On entry to CONVERT, `dac_code` is loaded with the MSB only (bit N-1 set) and bit index = N-1.
- **CONVERT** (one bit per cycle, `conv_clk_en`=1):
  - Each edge samples `comp_in` for the current bit index i.
  - If `comp_in`=0, bit i is cleared; if 1, bit i is kept.
  - If i>0, bit i-1 is then set and i decrements.
  - When i=0 is resolved, `result` is loaded with the final code and state goes to HOLD.
  - Bits above i are never modified after they are resolved.
- **HOLD:**
  - `result_valid`=1. `result` is held constant until the handshake completes.
  - `dac_code` holds the final code.
  - `conv_clk_en`=0, `sample_en`=0.
  - When `result_valid` && `result_ready`, the state goes to IDLE, or to SAMPLE if `start` is also high that edge.
- **IDLE:** `dac_code`=0. `result` retains its last value, but `result_valid`=0.
- Arithmetic: the bit index is $clog2(N) bits wide and only decrements; there is no wrap-around.

## Timing
- Let E0 be the edge where start is accepted.
- `sample_en` and `busy` are high from after E0 through edge E(SAMPLE_CYCLES).
- The first compare occurs at edge E(SAMPLE_CYCLES+1) and the last at E(SAMPLE_CYCLES+N).
- `conv_clk_en` is high for exactly N cycles.
- `result_valid` rises after E(SAMPLE_CYCLES+N), i.e. latency is SAMPLE_CYCLES+N cycles. With defaults that is 10.
- `comp_in` must be settled before the edge that samples it. It is used unregistered by the sequencer, with no extra pipeline stage.
- Back-to-back throughput: with `result_ready` tied high and `start` tied high, one result is produced every SAMPLE_CYCLES+N+1 cycles.
- All outputs are registered.
- `missed_start` is never asserted on an accepting edge.

## Test plan
- **Ramp code, default parameters:** reset, then pulse `start` with a comparator model `comp_in` = (0xA5 ≥ `dac_code`) -> `dac_code` sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; `result`=0xA5; `result_valid` high 10 cycles after the start edge; `conv_clk_en` high exactly 8 cycles.
- **Extremes:** Vin=0x00 -> `result`=0x00. Vin=0xFF -> `result`=0xFF. Vin=0x80 -> `result`=0x80.
- **Backpressure:** hold `result_ready`=0 for 5 cycles after valid -> `result_valid` and `result` remain stable, `busy` stays 1. Then raise ready with `start`=1 -> next edge `sample_en`=1, `result_valid`=0.
- **Dropped start:** pulse `start` during CONVERT -> one-cycle `missed_start` pulse; the result is unchanged and timing matches an unperturbed run.
- **Reset mid-conversion:** drive `rst_n`=0 on the 3rd CONVERT cycle -> next edge all outputs 0, state IDLE. A following start converts correctly from scratch.
- **Parameter sweep:** N=4 with SAMPLE_CYCLES=1, and N=12 with SAMPLE_CYCLES=3, using random Vin (1000 samples each) -> `result` equals Vin, and latency equals SAMPLE_CYCLES+N.
